// File: rtl/echo_cancel_sequencer.sv
// Sample-rate sequencer for the echo-cancel datapath: divider tick -> capture -> LOAD/FILTER/ERROR/[UPDATE]/DONE.
// Tick to out_valid is TAP_LENGTH+3 cycles (2*TAP_LENGTH+3 when adapting); no backpressure, ticks while busy are dropped and flag overrun.
module echo_cancel_sequencer #(
  parameter int DATA_WIDTH = 16,
  parameter int TAP_LENGTH = 64,
  parameter int SAMPLE_DIV = 12500
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          run,
  input  logic                          adapt_en,
  input  logic                          ovr_clr,
  input  logic [DATA_WIDTH-1:0]         sample_in,
  input  logic [DATA_WIDTH-1:0]         echo_in,
  output logic [DATA_WIDTH-1:0]         x_out,
  output logic [DATA_WIDTH-1:0]         d_out,
  output logic                          shift_en,
  output logic                          mac_clr,
  output logic                          mac_en,
  output logic [$clog2(TAP_LENGTH)-1:0] tap_addr,
  output logic                          err_latch,
  output logic                          coef_we,
  output logic                          out_valid,
  output logic                          busy,
  output logic                          overrun,
  output logic [15:0]                   sample_cnt
);

  localparam int AW    = $clog2(TAP_LENGTH);
  localparam int DIV_W = $clog2(SAMPLE_DIV);

  localparam logic [AW-1:0]    TAP_LAST = AW'(TAP_LENGTH - 1);
  localparam logic [AW-1:0]    TAP_ONE  = AW'(1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    FILTER,
    ERROR,
    UPDATE,
    DONE
  } state_t;

  state_t          state;
  logic [DIV_W-1:0] div_cnt;
  logic [AW-1:0]    tap_cnt;
  logic             adapt_q;
  logic             tick;

  assign tick = run && (div_cnt == DIV_LAST);

  // Sample-rate divider; stopping run only freezes ticks, never the sequence.
  always_ff @(posedge clk) begin
    if (!rst) begin
      div_cnt <= '0;
    end else if (!run || (div_cnt == DIV_LAST)) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      tap_cnt    <= '0;
      adapt_q    <= 1'b0;
      x_out      <= '0;
      d_out      <= '0;
      shift_en   <= 1'b0;
      mac_clr    <= 1'b0;
      mac_en     <= 1'b0;
      tap_addr   <= '0;
      err_latch  <= 1'b0;
      coef_we    <= 1'b0;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
      overrun    <= 1'b0;
      sample_cnt <= '0;
    end else begin
      shift_en  <= 1'b0;
      mac_clr   <= 1'b0;
      mac_en    <= 1'b0;
      tap_addr  <= '0;
      err_latch <= 1'b0;
      coef_we   <= 1'b0;
      out_valid <= 1'b0;

      // A dropped tick outranks a simultaneous clear.
      if (ovr_clr) begin
        overrun <= 1'b0;
      end
      if (tick && (state != IDLE)) begin
        overrun <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (tick) begin
            x_out    <= sample_in;
            d_out    <= echo_in;
            adapt_q  <= adapt_en;
            shift_en <= 1'b1;
            mac_clr  <= 1'b1;
            busy     <= 1'b1;
            state    <= LOAD;
          end
        end

        LOAD: begin
          tap_cnt  <= '0;
          mac_en   <= 1'b1;
          tap_addr <= '0;
          state    <= FILTER;
        end

        FILTER: begin
          if (tap_cnt == TAP_LAST) begin
            tap_cnt   <= '0;
            err_latch <= 1'b1;
            state     <= ERROR;
          end else begin
            tap_cnt  <= tap_cnt + TAP_ONE;
            mac_en   <= 1'b1;
            tap_addr <= tap_cnt + TAP_ONE;
          end
        end

        ERROR: begin
          tap_cnt <= '0;
          if (adapt_q) begin
            coef_we  <= 1'b1;
            tap_addr <= '0;
            state    <= UPDATE;
          end else begin
            out_valid  <= 1'b1;
            sample_cnt <= sample_cnt + 16'd1;
            state      <= DONE;
          end
        end

        UPDATE: begin
          if (tap_cnt == TAP_LAST) begin
            tap_cnt    <= '0;
            out_valid  <= 1'b1;
            sample_cnt <= sample_cnt + 16'd1;
            state      <= DONE;
          end else begin
            tap_cnt  <= tap_cnt + TAP_ONE;
            coef_we  <= 1'b1;
            tap_addr <= tap_cnt + TAP_ONE;
          end
        end

        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_echo_cancel_sequencer.sv
// Scoreboard bench: stimulus queues expected sequences, a negedge monitor checks strobes, slots and results.
module tb_echo_cancel_sequencer;

  localparam int TAP  = 8;
  localparam int DIV  = 24;
  localparam int DIV2 = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, run, adapt_en, ovr_clr;
  logic [15:0] sample_in, echo_in, x_out, d_out, sample_cnt;
  logic        shift_en, mac_clr, mac_en, err_latch, coef_we, out_valid, busy, overrun;
  logic [2:0]  tap_addr;

  logic        o_run, o_adapt, o_clr;
  logic [15:0] o_smp, o_echo, o_x, o_d, o_cnt;
  logic        o_shift, o_mclr, o_mac, o_err, o_coef, o_ov, o_busy, o_ovr;
  logic [2:0]  o_tap;

  echo_cancel_sequencer #(.DATA_WIDTH(16), .TAP_LENGTH(TAP), .SAMPLE_DIV(DIV)) dut (
    .clk(clk), .rst(rst), .run(run), .adapt_en(adapt_en), .ovr_clr(ovr_clr),
    .sample_in(sample_in), .echo_in(echo_in), .x_out(x_out), .d_out(d_out),
    .shift_en(shift_en), .mac_clr(mac_clr), .mac_en(mac_en), .tap_addr(tap_addr),
    .err_latch(err_latch), .coef_we(coef_we), .out_valid(out_valid), .busy(busy),
    .overrun(overrun), .sample_cnt(sample_cnt)
  );

  // Divider deliberately shorter than the busy span so ticks get dropped.
  echo_cancel_sequencer #(.DATA_WIDTH(16), .TAP_LENGTH(TAP), .SAMPLE_DIV(DIV2)) dut_ovr (
    .clk(clk), .rst(rst), .run(o_run), .adapt_en(o_adapt), .ovr_clr(o_clr),
    .sample_in(o_smp), .echo_in(o_echo), .x_out(o_x), .d_out(o_d),
    .shift_en(o_shift), .mac_clr(o_mclr), .mac_en(o_mac), .tap_addr(o_tap),
    .err_latch(o_err), .coef_we(o_coef), .out_valid(o_ov), .busy(o_busy),
    .overrun(o_ovr), .sample_cnt(o_cnt)
  );

  logic [58:0] main_vec;
  assign main_vec = {x_out, d_out, shift_en, mac_clr, mac_en, tap_addr, err_latch,
                     coef_we, out_valid, busy, overrun, sample_cnt};

  typedef struct {
    logic [15:0] x;
    logic [15:0] d;
    logic [15:0] cnt;
    int          coefs;
    int          lat;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0, m_div = 0, m2_div = 0;
  int last_tick = -100, t_load = 0, mac_n = 0, err_n = 0, coef_n = 0;
  int n_load = 0, n_strobe = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push(input logic [15:0] x, input logic [15:0] d, input logic [15:0] cnt, input int coefs);
    exp_t e;
    e.x = x; e.d = d; e.cnt = cnt; e.coefs = coefs;
    e.lat = TAP + 2 + coefs;
    sb.push_back(e);
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input string nm, input int budget);
    int k = 0;
    while (sb.size() != 0 && k < budget) begin
      next_cyc();
      k++;
    end
    chk(nm, 64'(sb.size()), 0);
  endtask

  task automatic wait_load(input string nm, input int budget);
    int k = 0;
    do begin
      next_cyc();
      k++;
    end while (!shift_en && k < budget);
    chk(nm, shift_en, 1);
  endtask

  task automatic wait_m2_tick(input string nm);
    int k = 0;
    do begin
      next_cyc();
      k++;
    end while (!(o_run && m2_div == DIV2 - 1) && k < 40);
    chk(nm, m2_div == DIV2 - 1, 1);
  endtask

  // Reference dividers, straight from the tick definition.
  always @(posedge clk) begin
    cyc    <= cyc + 1;
    m_div  <= (!rst || !run || m_div == DIV - 1) ? 0 : m_div + 1;
    m2_div <= (!rst || !o_run || m2_div == DIV2 - 1) ? 0 : m2_div + 1;
  end

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst) begin
      mac_n = 0; err_n = 0; coef_n = 0;
    end else begin
      if (run && m_div == DIV - 1) last_tick = cyc;
      if (shift_en || mac_clr || mac_en || err_latch || coef_we || out_valid) n_strobe++;
      if (shift_en) begin
        n_load++;
        chk("load_after_tick", 64'(cyc - last_tick), 1);
        chk("load_mac_clr", mac_clr, 1);
        chk("load_busy", busy, 1);
        chk("load_expected", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          chk("x_out", x_out, sb[0].x);
          chk("d_out", d_out, sb[0].d);
        end
        t_load = cyc; mac_n = 0; err_n = 0; coef_n = 0;
      end
      if (mac_en) begin
        chk("mac_tap_addr", tap_addr, 64'(mac_n));
        chk("mac_slot", 64'(cyc - t_load), 64'(mac_n + 1));
        mac_n++;
      end
      if (err_latch) begin
        chk("err_slot", 64'(cyc - t_load), TAP + 1);
        err_n++;
      end
      if (coef_we) begin
        chk("coef_tap_addr", tap_addr, 64'(coef_n));
        chk("coef_slot", 64'(cyc - t_load), 64'(TAP + 2 + coef_n));
        coef_n++;
      end
      if (!mac_en && !coef_we) chk("tap_addr_idle", tap_addr, 0);
      if (out_valid) begin
        chk("out_expected", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("out_latency", 64'(cyc - t_load), 64'(e.lat));
          chk("sample_cnt", sample_cnt, e.cnt);
          chk("mac_count", 64'(mac_n), TAP);
          chk("err_count", 64'(err_n), 1);
          chk("coef_count", 64'(coef_n), 64'(e.coefs));
          chk("out_busy", busy, 1);
          chk("x_hold", x_out, e.x);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got %0d cycles, expected fewer", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; run = 1'b0; adapt_en = 1'b0; ovr_clr = 1'b0; sample_in = '0; echo_in = '0;
    o_run = 1'b0; o_adapt = 1'b0; o_clr = 1'b0; o_smp = '0; o_echo = '0;

    for (int i = 0; i < 5; i++) begin
      run = 1'($urandom); adapt_en = 1'($urandom); ovr_clr = 1'($urandom);
      sample_in = 16'($urandom); echo_in = 16'($urandom);
      next_cyc();
      chk("reset_outputs", 64'(main_vec), 0);
    end

    rst = 1'b1; run = 1'b0; adapt_en = 1'b0; ovr_clr = 1'b0;
    repeat (100) next_cyc();
    chk("idle_busy", busy, 0);
    chk("idle_strobes", 64'(n_strobe), 0);

    sample_in = 16'h1234; echo_in = 16'hFFF0; adapt_en = 1'b1;
    push(16'h1234, 16'hFFF0, 16'd1, TAP);
    run = 1'b1;
    wait_drain("nominal_adapt_done", 80);

    next_cyc();
    sample_in = 16'h7FFF; echo_in = 16'h8000; adapt_en = 1'b0;
    push(16'h7FFF, 16'h8000, 16'd2, 0);
    wait_load("noadapt_load", 40);
    repeat (3) next_cyc();
    adapt_en = 1'b1;
    wait_drain("noadapt_done", 40);

    next_cyc();
    sample_in = 16'hABCD; echo_in = 16'h0001;
    push(16'hABCD, 16'h0001, 16'd3, TAP);
    wait_load("adapt_toggle_load", 40);
    repeat (3) next_cyc();
    adapt_en = 1'b0;
    wait_drain("adapt_toggle_done", 40);

    next_cyc();
    sample_in = 16'h0BAD; echo_in = 16'h0123; adapt_en = 1'b1;
    push(16'h0BAD, 16'h0123, 16'd4, TAP);
    begin
      int k = 0;
      do begin
        next_cyc();
        k++;
      end while (!(mac_en && tap_addr == 3'd3) && k < 60);
      chk("abort_reach_tap3", tap_addr, 3);
    end
    rst = 1'b0;
    sb.delete();
    next_cyc();
    chk("abort_outputs", 64'(main_vec), 0);
    sample_in = 16'h0F0F; echo_in = 16'h1111; adapt_en = 1'b1;
    push(16'h0F0F, 16'h1111, 16'd1, TAP);
    rst = 1'b1;
    wait_drain("after_abort_done", 80);

    next_cyc();
    force dut.sample_cnt = 16'hFFFF;
    next_cyc();
    release dut.sample_cnt;
    sample_in = 16'h5555; echo_in = 16'hAAAA; adapt_en = 1'b0;
    push(16'h5555, 16'hAAAA, 16'd0, 0);
    wait_load("wrap_load", 40);
    next_cyc();
    run = 1'b0;
    wait_drain("wrap_done", 40);
    repeat (60) next_cyc();
    chk("stopped_busy", busy, 0);
    chk("stopped_cnt", sample_cnt, 0);
    chk("load_total", 64'(n_load), 6);

    o_smp = 16'h1111; o_echo = 16'h2222; o_adapt = 1'b1; o_run = 1'b1;
    wait_m2_tick("ovr_tick0");
    next_cyc();
    chk("ovr_first_load", o_shift, 1);
    o_smp = 16'h3333;
    wait_m2_tick("ovr_tick1");
    next_cyc();
    chk("ovr_set", o_ovr, 1);
    chk("ovr_x_held", o_x, 16'h1111);
    chk("ovr_cnt_dropped", o_cnt, 0);
    wait_m2_tick("ovr_tick2");
    next_cyc();
    chk("ovr_second_load", o_shift, 1);
    chk("ovr_second_x", o_x, 16'h3333);
    o_smp = 16'h4444;
    wait_m2_tick("ovr_tick3");
    o_clr = 1'b1;
    next_cyc();
    o_clr = 1'b0;
    chk("ovr_set_wins", o_ovr, 1);
    chk("ovr_x_held2", o_x, 16'h3333);
    chk("ovr_cnt_one", o_cnt, 1);
    next_cyc();
    o_clr = 1'b1;
    next_cyc();
    o_clr = 1'b0;
    chk("ovr_cleared", o_ovr, 0);
    o_run = 1'b0;
    repeat (40) next_cyc();
    chk("ovr_cnt_final", o_cnt, 2);
    chk("ovr_idle", o_busy, 0);
    chk("ovr_stays_clear", o_ovr, 0);

    chk("scoreboard_empty", 64'(sb.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
